// File: rtl/cwm_pkg.sv
// Shared definitions for the RGB PWM driver: FSM states and PWM constants.
package cwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int unsigned PWM_WIDTH = 8;
    localparam logic [PWM_WIDTH-1:0] DUTY_FULL = 8'hFF;

endpackage

// File: rtl/pwm_channel.sv
// One PWM output pin: registered compare of the shared PWM count against a duty byte.
module pwm_channel
    import cwm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [PWM_WIDTH-1:0] pwm_cnt,
    input  logic [PWM_WIDTH-1:0] duty,
    output logic                 led
);

    // Full duty is forced on so 8'hFF means solid, not 255/256.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led <= 1'b0;
        end else begin
            led <= run && ((duty == DUTY_FULL) || (pwm_cnt < duty));
        end
    end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit PWM LED driver with period-aligned double-buffered colour.
module rgb_pwm_driver
    import cwm_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] light,
    output logic        led_r,
    output logic        led_g,
    output logic        led_b,
    output logic        period_start
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PWM_WIDTH-1:0] PWM_LAST = '1;

    state_t                 state;
    logic [PW-1:0]          presc_cnt;
    logic [PWM_WIDTH-1:0]   pwm_cnt;
    logic [23:0]            shadow_rgb;
    logic                   tick;
    logic                   run;

    assign tick = (presc_cnt == PRESC_LAST);
    assign run  = (state == RUN) && enable;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            presc_cnt    <= '0;
            pwm_cnt      <= '0;
            shadow_rgb   <= '0;
            period_start <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    presc_cnt    <= '0;
                    pwm_cnt      <= '0;
                    period_start <= 1'b0;
                    if (enable) state <= LOAD;
                end
                LOAD: begin
                    shadow_rgb   <= light;
                    presc_cnt    <= '0;
                    pwm_cnt      <= '0;
                    period_start <= 1'b0;
                    state        <= RUN;
                end
                RUN: begin
                    // Boundary shadow load happens even if enable drops in the same cycle.
                    if (tick && (pwm_cnt == PWM_LAST)) shadow_rgb <= light;
                    if (enable) begin
                        presc_cnt    <= tick ? '0 : presc_cnt + 1'b1;
                        if (tick) pwm_cnt <= pwm_cnt + 1'b1;
                        period_start <= (presc_cnt == '0) && (pwm_cnt == '0);
                    end else begin
                        presc_cnt    <= '0;
                        pwm_cnt      <= '0;
                        period_start <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    presc_cnt    <= '0;
                    pwm_cnt      <= '0;
                    period_start <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    pwm_channel u_red (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .pwm_cnt (pwm_cnt),
        .duty    (shadow_rgb[23:16]),
        .led     (led_r)
    );

    pwm_channel u_green (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .pwm_cnt (pwm_cnt),
        .duty    (shadow_rgb[15:8]),
        .led     (led_g)
    );

    pwm_channel u_blue (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .pwm_cnt (pwm_cnt),
        .duty    (shadow_rgb[7:0]),
        .led     (led_b)
    );

endmodule
